dino_renderer: RTL and testbench



---
 rtl/dino_pkg.sv | 23 ++
 rtl/dino_renderer_if.sv | 21 ++
 rtl/dino_jump_fsm.sv | 107 ++++++++++
 rtl/dino_renderer.sv | 106 ++++++++++
 tb/tb_dino_renderer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/dino_pkg.sv
// dino_pkg: shared types and constants for the dino renderer slice.
//   jump_state_e  - jump FSM state (IDLE, RISE, FALL)
//   H_VISIBLE / V_VISIBLE - visible screen size in pixels
//   SPRITE_SIZE   - dino block edge length in pixels
//   HEIGHT_W / VEL_W - widths of the jump height and velocity registers
//   ROW_W / COL_W - widths of the generator row/column addresses
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } jump_state_e;

  localparam int H_VISIBLE   = 640;
  localparam int V_VISIBLE   = 480;
  localparam int SPRITE_SIZE = 32;
  localparam int HEIGHT_W    = 8;
  localparam int VEL_W       = 5;
  localparam int ROW_W       = 9;
  localparam int COL_W       = 10;

endpackage

// File: rtl/dino_renderer_if.sv
// dino_renderer_if: pixel request bus between the VGA timing generator
// (master) and the pixel source (slave).
//   rdn      - request strobe, active-low; low marks a visible pixel request
//   row_addr - requested row
//   col_addr - requested column
//   px       - pixel answer, 1 = black
// Handshake: a request is valid in any cycle where rdn = 0. There is no
// ready; the slave must answer combinationally in that same cycle, and px
// must read 0 whenever rdn = 1.
interface dino_renderer_if;
  import dino_pkg::*;

  logic             rdn;
  logic [ROW_W-1:0] row_addr;
  logic [COL_W-1:0] col_addr;
  logic             px;

  modport master (output rdn, output row_addr, output col_addr, input px);
  modport slave  (input rdn, input row_addr, input col_addr, output px);

endinterface

// File: rtl/dino_jump_fsm.sv
// dino_jump_fsm: per-frame jump/gravity state machine for the dino.
//   vga_clk, clrn - pixel clock, asynchronous active-low reset
//   frame_update  - one-cycle strobe; all jump state advances only here
//   jump          - asynchronous button level
//   height        - current height above ground in pixels
//   airborne      - high while in RISE or FALL
//   state         - current FSM state, exposed for debug
// The button is synchronized and latched into jump_req while IDLE, so a
// press of any length between frame updates starts a jump at the next one.
module dino_jump_fsm
  import dino_pkg::*;
#(
  parameter int JUMP_V = 12
) (
  input  logic                vga_clk,
  input  logic                clrn,
  input  logic                frame_update,
  input  logic                jump,
  output logic [HEIGHT_W-1:0] height,
  output logic                airborne,
  output jump_state_e         state
);

  localparam logic [VEL_W-1:0] JUMP_VEL = VEL_W'(JUMP_V);

  logic sync1_q, sync2_q;
  logic jump_req_q, jump_req_d;

  jump_state_e         state_q;
  logic [HEIGHT_W-1:0] height_q;
  logic [VEL_W-1:0]    vel_q;
  logic                airborne_q;
  logic [VEL_W-1:0]    fall_nv;

  // Clearing on frame_update wins over setting, so a request is consumed
  // exactly once by the update that reads it.
  always_comb begin
    jump_req_d = jump_req_q | (sync2_q & (state_q == IDLE));
    if (frame_update) jump_req_d = 1'b0;
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      jump_req_q <= 1'b0;
    end else begin
      sync1_q    <= jump;
      sync2_q    <= sync1_q;
      jump_req_q <= jump_req_d;
    end
  end

  // Falling speed after this frame's gravity step.
  assign fall_nv = vel_q + VEL_W'(1);

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      height_q   <= '0;
      vel_q      <= '0;
      airborne_q <= 1'b0;
    end else if (frame_update) begin
      case (state_q)
        IDLE: begin
          if (jump_req_q) begin
            state_q    <= RISE;
            vel_q      <= JUMP_VEL;
            airborne_q <= 1'b1;
          end
        end
        RISE: begin
          height_q <= height_q + HEIGHT_W'(vel_q);
          if (vel_q == VEL_W'(1)) begin
            state_q <= FALL;
            vel_q   <= '0;
          end else begin
            vel_q <= vel_q - VEL_W'(1);
          end
        end
        FALL: begin
          // Landing clamps to the ground instead of letting height wrap.
          if (height_q <= HEIGHT_W'(fall_nv)) begin
            state_q    <= IDLE;
            height_q   <= '0;
            vel_q      <= '0;
            airborne_q <= 1'b0;
          end else begin
            height_q <= height_q - HEIGHT_W'(fall_nv);
            vel_q    <= fall_nv;
          end
        end
        default: begin
          state_q    <= IDLE;
          height_q   <= '0;
          vel_q      <= '0;
          airborne_q <= 1'b0;
        end
      endcase
    end
  end

  assign height   = height_q;
  assign airborne = airborne_q;
  assign state    = state_q;

endmodule

// File: rtl/dino_renderer.sv
// dino_renderer: monochrome pixel source for the VGA timing generator.
// Draws a solid ground band, an optional scrolling dashed ground texture
// and a 32x32 dino block that jumps under a per-frame gravity model.
//   vga_clk, clrn - pixel clock, asynchronous active-low reset
//   vga           - pixel request bus (slave side): rdn/row_addr/col_addr in,
//                   px out with zero latency
//   jump          - asynchronous jump button level
//   frame_tick    - one-cycle pulse after the last visible pixel of a frame
//   airborne      - high while the dino is rising or falling
//   dbg_state     - jump FSM state, for debug visibility
// Build option: define GROUND_TEXTURE_EN to include the scrolling texture;
// without it the offset counter is absent and texture rows stay white.
module dino_renderer
  import dino_pkg::*;
#(
  parameter int GROUND_Y = 400,
  parameter int DINO_X   = 64,
  parameter int JUMP_V   = 12
`ifdef GROUND_TEXTURE_EN
  , parameter int SCROLL_SPEED = 4
`endif
) (
  input  logic                  vga_clk,
  input  logic                  clrn,
  dino_renderer_if.slave        vga,
  input  logic                  jump,
  output logic                  frame_tick,
  output logic                  airborne,
  output jump_state_e           dbg_state
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(V_VISIBLE - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_VISIBLE - 1);
  localparam logic [9:0]       GND_TOP  = 10'(GROUND_Y);
  localparam logic [9:0]       GND_BOT  = 10'(GROUND_Y + 8);
  localparam logic [9:0]       DINO_TOP = 10'(GROUND_Y - SPRITE_SIZE);
  localparam logic [COL_W-1:0] DINO_L   = COL_W'(DINO_X);
  localparam logic [COL_W-1:0] DINO_R   = COL_W'(DINO_X + SPRITE_SIZE);

  logic                frame_cond;
  logic                frame_tick_q, frame_tick_d;
  logic [HEIGHT_W-1:0] height;
  logic [9:0]          row10;
  logic [9:0]          dino_y;
  logic                ground, texture, dino;

  // The last visible pixel only ever appears once per frame with rdn low;
  // during blanking row_addr aliases through the same values with rdn high.
  assign frame_cond = !vga.rdn && (vga.row_addr == LAST_ROW) &&
                      (vga.col_addr == LAST_COL);

  always_comb frame_tick_d = frame_cond;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) frame_tick_q <= 1'b0;
    else       frame_tick_q <= frame_tick_d;
  end

  dino_jump_fsm #(
    .JUMP_V (JUMP_V)
  ) u_jump_fsm (
    .vga_clk      (vga_clk),
    .clrn         (clrn),
    .frame_update (frame_cond),
    .jump         (jump),
    .height       (height),
    .airborne     (airborne),
    .state        (dbg_state)
  );

`ifdef GROUND_TEXTURE_EN
  localparam logic [9:0] TEX_BOT = 10'(GROUND_Y + 12);

  logic [COL_W-1:0] offset_q, offset_d;
  logic [COL_W-1:0] tex_col;

  always_comb begin
    offset_d = offset_q;
    if (frame_cond) offset_d = offset_q + COL_W'(SCROLL_SPEED);
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) offset_q <= '0;
    else       offset_q <= offset_d;
  end

  // 10-bit add wraps modulo 1024; dashes are 8 on / 24 off.
  assign tex_col = vga.col_addr + offset_q;
  assign texture = (row10 >= GND_BOT) && (row10 < TEX_BOT) &&
                   (tex_col[4:0] < 5'd8);
`else
  assign texture = 1'b0;
`endif

  assign row10  = {1'b0, vga.row_addr};
  // Shifting the row down by the height avoids subtracting from GROUND_Y.
  assign dino_y = row10 + 10'(height);

  assign ground = (row10 >= GND_TOP) && (row10 < GND_BOT);
  assign dino   = (vga.col_addr >= DINO_L) && (vga.col_addr < DINO_R) &&
                  (dino_y >= DINO_TOP) && (dino_y < GND_TOP);

  assign vga.px     = !vga.rdn && (ground || texture || dino);
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_dino_renderer.sv
// tb_dino_renderer: randomized bench for dino_renderer. A driver issues
// pixel requests and frame-end pixels and pushes the expected
// {state, airborne, frame_tick, px} per cycle; a monitor pops and compares.
// The reference model tracks the jump as a frame count since take-off and
// derives height from closed-form triangular sums.
module tb_dino_renderer;
  import dino_pkg::*;

  localparam int GY   = 400;
  localparam int DX   = 64;
  localparam int V    = 12;
  localparam int PEAK = V * (V + 1) / 2;
  localparam int SPD  = 4;

  logic        vga_clk = 1'b0;
  logic        clrn;
  logic        jump;
  logic        frame_tick;
  logic        airborne;
  jump_state_e dbg_state;

  dino_renderer_if vga_if();

  dino_renderer dut (
    .vga_clk    (vga_clk),
    .clrn       (clrn),
    .vga        (vga_if),
    .jump       (jump),
    .frame_tick (frame_tick),
    .airborne   (airborne),
    .dbg_state  (dbg_state)
  );

  always #5 vga_clk = ~vga_clk;

  // scoreboard
  logic [4:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // reference model: t = frame updates since take-off (0 = on the ground)
  int t     = 0;
  int m_off = 0;
  bit req   = 0;
  bit jd1   = 0;
  bit jd2   = 0;
  bit tick_exp = 0;

  function automatic int model_height(input int tt);
    int m;
    if (tt == 0) return 0;
    if (tt <= V) return (tt - 1) * V - (tt - 1) * (tt - 2) / 2;
    m = tt - V - 1;
    return PEAK - m * (m + 1) / 2;
  endfunction

  function automatic logic [1:0] model_state();
    if (t == 0) return 2'(IDLE);
    if (t <= V) return 2'(RISE);
    return 2'(FALL);
  endfunction

  function automatic bit model_px(input bit rdn, input int row, input int col);
    int h;
    bit g, tx, d;
    h = model_height(t);
    if (rdn) return 1'b0;
    g  = (row >= GY) && (row < GY + 8);
    tx = 1'b0;
`ifdef GROUND_TEXTURE_EN
    tx = (row >= GY + 8) && (row < GY + 12) && ((((col + m_off) % 1024) % 32) < 8);
`endif
    d  = (col >= DX) && (col < DX + 32) &&
         (((row + h) % 1024) >= GY - 32) && (((row + h) % 1024) < GY);
    return g | tx | d;
  endfunction

  // model effect of one rising edge with clrn high
  task automatic step(input bit cond);
    int m;
    bit idle;
    idle = (t == 0);
    if (cond) begin
      m_off = (m_off + SPD) % 1024;
      if (t == 0) begin
        if (req) t = 1;
      end else begin
        t++;
        if (t > V) begin
          m = t - V - 1;
          if (PEAK <= m * (m + 1) / 2) t = 0;
        end
      end
      req = 0;
    end else if (jd2 && idle) begin
      req = 1;
    end
    jd2 = jd1;
    jd1 = jump;
    tick_exp = cond;
  endtask

  // one bus cycle: drive at negedge, push expectation, advance model
  task automatic drive(input bit rst_n, input bit rdn, input int row, input int col);
    bit cond;
    @(negedge vga_clk);
    clrn            = rst_n;
    vga_if.rdn      = rdn;
    vga_if.row_addr = 9'(row);
    vga_if.col_addr = 10'(col);
    if (!rst_n) begin
      t = 0; req = 0; jd1 = 0; jd2 = 0; m_off = 0; tick_exp = 0;
    end
    exp_q.push_back({model_state(), (t != 0), tick_exp, model_px(rdn, row, col)});
    cond = !rdn && (row == 479) && (col == 639);
    if (rst_n) step(cond);
  endtask

  task automatic probe_random(input bit rst_n);
    int kind, row, col;
    bit rdn;
    kind = $urandom_range(0, 5);
    rdn  = ($urandom_range(0, 7) == 0);
    case (kind)
      0: begin row = $urandom_range(280, 402); col = $urandom_range(60, 100); end
      1: begin row = $urandom_range(396, 415); col = $urandom_range(0, 639); end
      2: begin row = $urandom_range(0, 479);   col = $urandom_range(0, 639); end
      3: begin row = 479;                      col = $urandom_range(600, 639); end
      4: begin row = 479; col = 639; rdn = 1'b1; end
      default: begin row = $urandom_range(0, 511); col = $urandom_range(0, 1023); rdn = 1'b1; end
    endcase
    if (!rdn && row == 479 && col == 639) col = 638;
    drive(rst_n, rdn, row, col);
  endtask

  // a compressed frame: directed edge probes, random probes, then frame end;
  // jump is 'level' except during [ps, ps+pl) where it is forced high
  task automatic frame(input int nprobe, input bit level, input int ps, input int pl);
    int h;
    h = model_height(t);
    jump = level;
    drive(1, 0, 367 - h, DX);
    drive(1, 0, 368 - h, DX + 31);
    drive(1, 0, 368 - h, DX + 32);
    drive(1, 0, 399, DX - 1);
    drive(1, 0, 408, 0);
    for (int i = 0; i < nprobe; i++) begin
      jump = ((i >= ps) && (i < ps + pl)) ? 1'b1 : level;
      probe_random(1);
    end
    jump = level;
    drive(1, 0, 479, 639);
  endtask

  // monitor
  initial begin
    logic [4:0] e, g;
    forever begin
      @(negedge vga_clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = {dbg_state, airborne, frame_tick, vga_if.px};
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL cycle_check t=%0t rdn=%b row=%0d col=%0d got state/air/tick/px=%b required=%b",
                   $time, vga_if.rdn, vga_if.row_addr, vga_if.col_addr, g, e);
        end
      end
    end
  end

  // stimulus
  initial begin
    clrn = 1'b0;
    jump = 1'b0;
    vga_if.rdn = 1'b1;
    vga_if.row_addr = '0;
    vga_if.col_addr = '0;

    // reset values
    drive(0, 0, 400, 5);
    drive(0, 0, 399, DX);
    drive(0, 0, 367, DX);
    drive(0, 0, 408, 0);
    drive(0, 1, 400, 5);
    drive(0, 0, 479, 639);
    for (int i = 0; i < 4; i++) probe_random(0);

    // release, idle frames
    for (int i = 0; i < 4; i++) probe_random(1);
    for (int f = 0; f < 3; f++) frame(30, 1'b0, 0, 0);

    // single short press, full trajectory and a bit of ground time
    frame(30, 1'b0, 2, 3);
    for (int f = 0; f < 28; f++) frame(30, 1'b0, 0, 0);

    // held button: re-trigger on landing
    for (int f = 0; f < 55; f++) frame(30, 1'b1, 0, 0);
    jump = 1'b0;

    // pulses while airborne are ignored
    for (int f = 0; f < 26; f++) frame(30, 1'b0, 10, (f % 3 == 0) ? 4 : 0);

    // reset in the middle of the fall at height 50
    frame(30, 1'b0, 1, 3);
    for (int k = 0; k < 40 && t != 20; k++) frame(30, 1'b0, 0, 0);
    drive(0, 0, 399, DX);
    drive(0, 0, 318, DX);
    drive(0, 0, 408, 0);
    drive(0, 0, 479, 639);
    drive(1, 0, 399, DX);
    for (int f = 0; f < 3; f++) frame(30, 1'b0, 0, 0);

    // randomized frames, long enough for the scroll offset to wrap
    for (int f = 0; f < 270; f++) begin
      case ($urandom_range(0, 3))
        0: frame(30, 1'b0, 0, 0);
        1: frame(30, 1'b1, 0, 0);
        default: frame(30, 1'b0, $urandom_range(0, 25), $urandom_range(1, 6));
      endcase
    end

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge vga_clk);
    #5;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout got %0d pending entries required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
